// File: rtl/keyboard_ctl_if.sv
// Signal bundle between the PS/2 pads and keyboard_ctl, plus the decoder's debug taps.
// Handshake: scan_valid and frame_err are one-cycle strobes with no ready; scan_code is held until the next scan_valid.
interface keyboard_ctl_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       key_space;
    logic       key_left;
    logic       key_right;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_err;
    logic [1:0] dbg_state;
    logic [3:0] dbg_bit_cnt;

    modport master (
        output ps2_clk, ps2_data,
        input  key_space, key_left, key_right, scan_code, scan_valid, frame_err,
        input  dbg_state, dbg_bit_cnt
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output key_space, key_left, key_right, scan_code, scan_valid, frame_err,
        output dbg_state, dbg_bit_cnt
    );
endinterface

// File: rtl/keyboard_ctl.sv
// PS/2 device-to-host receiver with glitch filter and frame timeout, decoding
// make/break codes for Space, Left Arrow and Right Arrow into held key levels.
module keyboard_ctl #(
    parameter int CLK_FREQ_HZ = 40_000_000,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_US  = 1000
) (
    input  logic           clk,
    input  logic           rst,
    keyboard_ctl_if.slave  kb
);
    localparam int TO_CNT = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
    localparam int TO_W   = $clog2(TO_CNT + 1);
    localparam int FL_W   = $clog2(FILTER_LEN + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} dec_state_t;

    logic            clk_s1, clk_s2, dat_s1, dat_s2;
    logic            flt_clk;
    logic [FL_W-1:0] flt_cnt;
    logic            fall;

    logic [3:0]      bit_cnt;
    logic [9:0]      frame_q;
    logic [TO_W-1:0] to_cnt;
    logic            frame_ok;
    logic [7:0]      code_q;
    logic            scan_valid_q, frame_err_q;

    dec_state_t      state_q, state_d;
    logic            space_q, left_q, right_q;
    logic            space_d, left_d, right_d;

    // Synchronisers idle high so reset never looks like a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            dat_s1  <= 1'b1;
            dat_s2  <= 1'b1;
            flt_clk <= 1'b1;
            flt_cnt <= '0;
            fall    <= 1'b0;
        end else begin
            clk_s1 <= kb.ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= kb.ps2_data;
            dat_s2 <= dat_s1;
            fall   <= 1'b0;
            if (clk_s2 == flt_clk) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FL_W'(FILTER_LEN - 1)) begin
                flt_clk <= clk_s2;
                flt_cnt <= '0;
                fall    <= ~clk_s2;
            end else begin
                flt_cnt <= flt_cnt + FL_W'(1);
            end
        end
    end

    // After ten shifts frame_q holds {parity, data[7:0], start}; the stop bit is the live sample.
    assign frame_ok = !frame_q[0] && (^frame_q[9:1]) && dat_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt      <= '0;
            frame_q      <= '0;
            to_cnt       <= '0;
            code_q       <= '0;
            scan_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            scan_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (fall) begin
                to_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    if (frame_ok) begin
                        code_q       <= frame_q[8:1];
                        scan_valid_q <= 1'b1;
                    end else begin
                        frame_err_q <= 1'b1;
                    end
                end else begin
                    frame_q <= {dat_s2, frame_q[9:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                if (to_cnt == TO_W'(TO_CNT - 1)) begin
                    bit_cnt     <= '0;
                    to_cnt      <= '0;
                    frame_err_q <= 1'b1;
                end else begin
                    to_cnt <= to_cnt + TO_W'(1);
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            space_q <= 1'b0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
        end else begin
            state_q <= state_d;
            space_q <= space_d;
            left_q  <= left_d;
            right_q <= right_d;
        end
    end

    // A discarded frame drops any pending prefix but keeps the held levels.
    always_comb begin
        state_d = state_q;
        space_d = space_q;
        left_d  = left_q;
        right_d = right_q;
        if (frame_err_q) begin
            state_d = ST_IDLE;
        end else if (scan_valid_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (code_q == 8'hE0)      state_d = ST_EXT;
                    else if (code_q == 8'hF0) state_d = ST_BRK;
                    else if (code_q == 8'h29) space_d = 1'b1;
                end
                ST_EXT: begin
                    if (code_q == 8'hF0) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        state_d = ST_IDLE;
                        if (code_q == 8'h6B) left_d  = 1'b1;
                        if (code_q == 8'h74) right_d = 1'b1;
                    end
                end
                ST_BRK: begin
                    state_d = ST_IDLE;
                    if (code_q == 8'h29) space_d = 1'b0;
                end
                ST_EXT_BRK: begin
                    state_d = ST_IDLE;
                    if (code_q == 8'h6B) left_d  = 1'b0;
                    if (code_q == 8'h74) right_d = 1'b0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign kb.key_space   = space_q;
    assign kb.key_left    = left_q;
    assign kb.key_right   = right_q;
    assign kb.scan_code   = code_q;
    assign kb.scan_valid  = scan_valid_q;
    assign kb.frame_err   = frame_err_q;
    assign kb.dbg_state   = state_q;
    assign kb.dbg_bit_cnt = bit_cnt;
endmodule

// File: doc/keyboard_ctl.md
# keyboard_ctl

PS/2 keyboard receiver and key-state decoder feeding the player-motion controller. Deserialises PS/2 device-to-host frames and tracks make/break codes for Space, Left Arrow and Right Arrow. Presents three held key levels (`key_space`, `key_left`, `key_right`) on the system clock for the jump/rect control stage downstream. Also emits each received byte and a frame-error strobe for debug.

## Interface
- `CLK_FREQ_HZ`, 40_000_000: system clock frequency; used to derive the timeout count.
- `FILTER_LEN`, 8: consecutive equal samples needed before the filtered `ps2_clk` changes level.
- `TIMEOUT_US`, 1000: maximum gap between falling edges inside one frame before the frame is aborted.
- `clk` input 1: system clock. Everything is on `posedge clk`.
- `rst` input 1: asynchronous, active-high reset.
- `ps2_clk` input 1: raw PS/2 clock from the pad, asynchronous.
- `ps2_data` input 1: raw PS/2 data from the pad, asynchronous.
- `key_space` output 1: high while Space (0x29) is held.
- `key_left` output 1: high while Left Arrow (E0 6B) is held.
- `key_right` output 1: high while Right Arrow (E0 74) is held.
- `scan_code` output 8: last correctly received byte.
- `scan_valid` output 1: one-cycle strobe when `scan_code` updates.
- `frame_err` output 1: one-cycle strobe on a discarded frame.

## Operation
- **Input conditioning**
  - `ps2_clk` and `ps2_data` each pass through a 2-FF synchroniser.
  - The synchronised clock drives a filter counter. The filtered level toggles only after `FILTER_LEN` consecutive samples differ from the current filtered level.
  - A falling edge of the filtered clock produces a one-cycle `fall` strobe. Synchronised data is sampled on that strobe.
- **Frame receiver**
  - Bit counter runs 0..10: start bit, 8 data bits LSB first, odd parity, stop bit.
  - On bit 10, the frame is accepted only if all three hold: start = 0, XOR of data and parity = 1, stop = 1.
  - Accepted frame: load `scan_code`, pulse `scan_valid`.
  - Rejected frame: pulse `frame_err`, `scan_code` unchanged.
  - Either way the bit counter returns to 0.
- **Timeout**
  - A counter of `CLK_FREQ_HZ/1_000_000*TIMEOUT_US` cycles restarts on every `fall`.
  - It expires only while the bit counter is non-zero. On expiry: bit counter = 0, pulse `frame_err`.
- **Decoder FSM**, advanced only on `scan_valid`.
  - States: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
  - IDLE: E0 -> EXT; F0 -> BRK; 29 -> `key_space`=1; else ignored; stays IDLE.
  - EXT: F0 -> EXT_BRK; 6B -> `key_left`=1, IDLE; 74 -> `key_right`=1, IDLE; else -> IDLE.
  - BRK: 29 -> `key_space`=0; any byte -> IDLE.
  - EXT_BRK: 6B -> `key_left`=0; 74 -> `key_right`=0; any byte -> IDLE.
  - Non-extended 6B/74 (keypad 4/6) affect no output.
  - Typematic repeat makes leave the level at 1. A break for a key not held leaves it at 0.
  - `frame_err` forces the FSM to IDLE, dropping any pending prefix. Key levels are kept.
- **Reset**: all outputs 0 (`scan_code`=8'h00), FSM IDLE, counters 0, filtered clock = 1. An in-progress frame is discarded.

## Timing
- Cycle N is the cycle `fall` is asserted for the stop bit.
  - N+1: `scan_valid` or `frame_err` high for exactly one cycle; `scan_code` updated.
  - N+2: `key_*` levels reflect that byte.
- Pin-to-`fall` latency is 2 (sync) + `FILTER_LEN` cycles.
- Timeout `frame_err` is asserted the cycle after the counter reaches its terminal count.
- `scan_valid` and `frame_err` are never high together.
- Minimum legal PS/2 bit period (60 µs) far exceeds filter latency, so back-to-back frames lose no bits.

## Test plan
1. Frame 0x29, parity 0 -> `scan_valid` pulse, `scan_code`=0x29, `key_space`=1 at N+2. Then F0, 29 -> `key_space`=0; other keys stay 0.
2. E0 6B -> `key_left`=1; E0 74 -> `key_right`=1. Then E0 F0 6B -> `key_left`=0 while `key_right` stays 1.
3. Non-extended 6B, then 29 repeated three times -> `key_left` stays 0; `key_space`=1 with no toggling.
4. Frame 0x29 with parity 1 -> `frame_err` pulse, no `scan_valid`, `key_space` stays 0. Next good 0x29 is accepted.
5. E0, then a frame truncated after 5 bits, then silence > `TIMEOUT_US` -> `frame_err`, FSM IDLE. Then 6B -> `key_left` stays 0. Then 29 -> `key_space`=1.
6. `ps2_clk` low glitch of 3 cycles (`FILTER_LEN`=8) -> no bit counted, and the next frame decodes correctly. `rst` mid-frame -> all outputs 0, and the following full 0x29 decodes correctly.
